// File: rtl/systola_mem_pkg.sv
// Shared definitions for the INPMEM port arbiters: default geometry,
// starvation limit and the grant encoding.
package systola_mem_pkg;
    localparam int AW_DEF         = 16;
    localparam int DW_DEF         = 8;
    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// Counts read grants taken while a load is waiting; saturates at STARVE_MAX
// and raises force_ld so the next arbitration goes to the load path.
module arb_starve_ctr
    import systola_mem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic ld_valid,
    input  logic rd_gnt,
    input  logic ld_gnt,
    output logic force_ld
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            // A waiting load that finally gets in, or no load at all, restarts the window.
            if (ld_gnt || !ld_valid) begin
                cnt_d = '0;
            end else if (rd_gnt && (cnt_q != MAX_CNT)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign force_ld = (cnt_q == MAX_CNT);
endmodule

// File: rtl/inpmem_port_arb.sv
// Single-port INPMEM arbiter: compute reads win, host loads are guaranteed a
// slot after STARVE_MAX consecutive read grants. SRAM pins follow the grant.
module inpmem_port_arb
    import systola_mem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_rvalid,
    output logic [DW-1:0] rd_rdata,
    output logic          mem_cen,
    output logic          mem_wen,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q,
    output logic          starve_evt
);
    gnt_t gnt;
    logic force_ld;
    logic forced;
    logic rd_rvalid_d, rd_rvalid_q;
    logic starve_evt_d, starve_evt_q;

    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .ld_valid (ld_valid),
        .rd_gnt   (gnt == GNT_RD),
        .ld_gnt   (gnt == GNT_WR),
        .force_ld (force_ld)
    );

    always_comb begin
        gnt    = GNT_NONE;
        forced = 1'b0;
        if (!rst && enable) begin
            if (force_ld && ld_valid) begin
                gnt    = GNT_WR;
                forced = 1'b1;
            end else if (rd_valid) begin
                gnt = GNT_RD;
            end else if (ld_valid) begin
                gnt = GNT_WR;
            end
        end
    end

    assign ld_ready = (gnt == GNT_WR);
    assign rd_ready = (gnt == GNT_RD);

    always_comb begin
        mem_cen = 1'b1;
        mem_wen = 1'b1;
        mem_a   = '0;
        mem_d   = '0;
        case (gnt)
            GNT_WR: begin
                mem_cen = 1'b0;
                mem_wen = 1'b0;
                mem_a   = ld_addr;
                mem_d   = ld_data;
            end
            GNT_RD: begin
                mem_cen = 1'b0;
                mem_a   = rd_addr;
            end
            default: ;
        endcase
    end

    // ready already implies valid, so the grant is the handshake.
    assign rd_rvalid_d  = (gnt == GNT_RD);
    assign starve_evt_d = forced;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_rvalid_q  <= 1'b0;
            starve_evt_q <= 1'b0;
        end else begin
            rd_rvalid_q  <= rd_rvalid_d;
            starve_evt_q <= starve_evt_d;
        end
    end

    // Gating with rst drops a read return that lands in the first reset cycle.
    assign rd_rvalid  = rd_rvalid_q & ~rst;
    assign starve_evt = starve_evt_q & ~rst;
    assign rd_rdata   = rd_rvalid ? mem_q : '0;
endmodule
